io_periph_hub: RTL



---
 rtl/io_periph_hub_pkg.sv | 34 +++
 rtl/io_periph_hub_if.sv | 14 +
 rtl/io_periph_hub_btn_debounce.sv | 47 ++++
 rtl/io_periph_hub.sv | 136 +++++++++++++
 4 files changed

// File: rtl/io_periph_hub_pkg.sv
// Shared definitions for io_periph_hub: bus widths, register map,
// reset values and the hex-to-segment table.
package io_periph_hub_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;

  // Word index of each register within the hub window (addr[4:2]).
  typedef enum logic [2:0] {
    REG_DIG  = 3'd0,
    REG_LED  = 3'd1,
    REG_SW   = 3'd2,
    REG_BTN  = 3'd3,
    REG_EVT  = 3'd4,
    REG_CTRL = 3'd5
  } reg_idx_e;

  localparam logic [31:0] DIG_RST       = 32'h0000_0000;
  localparam logic [31:0] LED_RST       = 32'h0000_0000;
  localparam logic [7:0]  EVT_RST       = 8'h00;
  localparam logic [7:0]  CTRL_MASK_RST = 8'hFF;
  localparam logic [7:0]  CTRL_DP_RST   = 8'h00;

  // Active-high g..a patterns, entry 15 first.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    return HEX_SEG[n];
  endfunction

endpackage

// File: rtl/io_periph_hub_if.sv
// Bridge-side register bus of the hub: chip-select, write strobe,
// byte address, write data and combinational read data.
interface io_periph_hub_if;
  import io_periph_hub_pkg::*;

  logic              sel;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (output sel, output we, output addr, output wdata, input rdata);
  modport slave  (input sel, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/io_periph_hub_btn_debounce.sv
// One button: two-flop synchroniser followed by a stability counter that
// accepts a new level after DEBOUNCE_CYC consecutive differing samples.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 200000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise_c
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic             r_s1;
  logic             r_s2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             w_done;

  assign w_done = (r_s2 != r_level) && (r_cnt == CNT_W'(DEBOUNCE_CYC - 1));

  // Any sample agreeing with the accepted level restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1 <= i_btn;
      r_s2 <= r_s1;
      if (r_s2 == r_level) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_cnt   <= '0;
        r_level <= r_s2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level  = r_level;
  assign o_rise_c = w_done & r_s2;

endmodule

// File: rtl/io_periph_hub.sv
// Memory-mapped board I/O hub: 7-segment scanner, LEDs, synchronised
// switches and debounced buttons with sticky press flags.
module io_periph_hub
  import io_periph_hub_pkg::*;
#(
  parameter int unsigned N_DIGITS     = 8,
  parameter int unsigned N_LED        = 16,
  parameter int unsigned N_SW         = 16,
  parameter int unsigned N_BTN        = 5,
  parameter int unsigned SCAN_DIV     = 20000,
  parameter int unsigned DEBOUNCE_CYC = 200000
) (
  input  logic                clk,
  input  logic                rst,
  io_periph_hub_if.slave      bus,
  input  logic [N_SW-1:0]     sw,
  input  logic [N_BTN-1:0]    button,
  output logic [N_LED-1:0]    led,
  output logic [7:0]          led_seg,
  output logic [N_DIGITS-1:0] dig_sel
);

  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DIG_W = 4 * N_DIGITS;

  logic [DIG_W-1:0]    r_dig;
  logic [N_LED-1:0]    r_led;
  logic [N_DIGITS-1:0] r_mask;
  logic [N_DIGITS-1:0] r_dp;
  logic [N_BTN-1:0]    r_evt;
  logic [N_SW-1:0]     r_sw_s1;
  logic [N_SW-1:0]     r_sw_s2;
  logic [DIV_W-1:0]    r_div;
  logic [IDX_W-1:0]    r_idx;
  logic [N_DIGITS-1:0] r_dig_sel;
  logic [7:0]          r_led_seg;

  logic                w_wr;
  reg_idx_e            w_ridx;
  logic [N_BTN-1:0]    w_btn_lvl;
  logic [N_BTN-1:0]    w_btn_rise;
  logic [N_BTN-1:0]    w_evt_clr;
  logic [N_DIGITS-1:0] w_onehot;
  logic [3:0]          w_nib;
  logic [DATA_W-1:0]   w_rdata;
  logic                w_unused;

  assign w_wr      = bus.sel & bus.we;
  assign w_ridx    = reg_idx_e'(bus.addr[4:2]);
  assign w_evt_clr = (w_wr && (w_ridx == REG_EVT)) ? bus.wdata[N_BTN-1:0] : '0;
  assign w_onehot  = N_DIGITS'(1) << r_idx;
  assign w_nib     = 4'(r_dig >> {r_idx, 2'b00});
  assign w_unused  = ^{bus.addr[1:0], bus.wdata};

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .clk      (clk),
      .rst      (rst),
      .i_btn    (button[g]),
      .o_level  (w_btn_lvl[g]),
      .o_rise_c (w_btn_rise[g])
    );
  end

  // Writable registers; a press arriving with a clear of the same bit wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dig   <= DIG_RST[DIG_W-1:0];
      r_led   <= LED_RST[N_LED-1:0];
      r_mask  <= CTRL_MASK_RST[N_DIGITS-1:0];
      r_dp    <= CTRL_DP_RST[N_DIGITS-1:0];
      r_evt   <= EVT_RST[N_BTN-1:0];
      r_sw_s1 <= '0;
      r_sw_s2 <= '0;
    end else begin
      r_sw_s1 <= sw;
      r_sw_s2 <= r_sw_s1;
      r_evt   <= (r_evt & ~w_evt_clr) | w_btn_rise;
      if (w_wr && (w_ridx == REG_DIG))  r_dig <= bus.wdata[DIG_W-1:0];
      if (w_wr && (w_ridx == REG_LED))  r_led <= bus.wdata[N_LED-1:0];
      if (w_wr && (w_ridx == REG_CTRL)) begin
        r_mask <= bus.wdata[N_DIGITS-1:0];
        r_dp   <= bus.wdata[8 +: N_DIGITS];
      end
    end
  end

  // Scanner; the output registers always show the digit at r_idx.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div     <= '0;
      r_idx     <= '0;
      r_dig_sel <= '1;
      r_led_seg <= 8'hFF;
    end else begin
      if (r_div == DIV_W'(SCAN_DIV - 1)) begin
        r_div <= '0;
        r_idx <= (r_idx == IDX_W'(N_DIGITS - 1)) ? '0 : r_idx + 1'b1;
      end else begin
        r_div <= r_div + 1'b1;
      end
      if (r_mask[r_idx]) begin
        r_dig_sel <= ~w_onehot;
        r_led_seg <= {~r_dp[r_idx], ~hex_seg(w_nib)};
      end else begin
        r_dig_sel <= '1;
        r_led_seg <= 8'hFF;
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    if (bus.sel) begin
      case (w_ridx)
        REG_DIG:  w_rdata = DATA_W'(r_dig);
        REG_LED:  w_rdata = DATA_W'(r_led);
        REG_SW:   w_rdata = DATA_W'(r_sw_s2);
        REG_BTN:  w_rdata = DATA_W'(w_btn_lvl);
        REG_EVT:  w_rdata = DATA_W'(r_evt);
        REG_CTRL: begin
          w_rdata[N_DIGITS-1:0]  = r_mask;
          w_rdata[8 +: N_DIGITS] = r_dp;
        end
        default:  w_rdata = '0;
      endcase
    end
  end

  assign bus.rdata = w_rdata;
  assign led       = r_led;
  assign led_seg   = r_led_seg;
  assign dig_sel   = r_dig_sel;

endmodule
